// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider between two requesters.
// Short-circuits divide-by-zero and reports a timeout if the divider never completes.
module divider_arbiter #(
  parameter int W       = 9,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] abus0,
  input  logic [W-1:0] bbus0,
  input  logic [W-1:0] abus1,
  input  logic [W-1:0] bbus1,
  output logic [1:0]   done,
  output logic [1:0]   err,
  output logic [W-1:0] qbus,
  output logic [W-1:0] rbus,
  output logic         div_start,
  output logic [W-1:0] div_abus,
  output logic [W-1:0] div_bbus,
  input  logic [W-1:0] div_qbus,
  input  logic [W-1:0] div_rbus,
  input  logic         div_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t         state_r;
  logic           ptr_r;
  logic           grant_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     done_r;
  logic [1:0]     err_r;
  logic [W-1:0]   q_r;
  logic [W-1:0]   r_r;
  logic           div_start_r;
  logic [W-1:0]   div_a_r;
  logic [W-1:0]   div_b_r;

  logic           pick_s;
  logic [W-1:0]   a_pick_s;
  logic [W-1:0]   b_pick_s;
  logic [CW-1:0]  cnt_inc_s;
  logic           expire_s;

  function automatic logic [1:0] onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  // Winner selection and timeout detection for the current cycle
  always_comb begin
    pick_s    = 1'b0;
    a_pick_s  = '0;
    b_pick_s  = '0;
    cnt_inc_s = '0;
    expire_s  = 1'b0;
    pick_s    = req[ptr_r] ? ptr_r : ~ptr_r;
    a_pick_s  = pick_s ? abus1 : abus0;
    b_pick_s  = pick_s ? bbus1 : bbus0;
    cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    expire_s  = (cnt_inc_s == CW'(TIMEOUT));
  end

  // Arbitration and divider sequencing FSM; all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      grant_r     <= 1'b0;
      cnt_r       <= '0;
      done_r      <= 2'b00;
      err_r       <= 2'b00;
      q_r         <= '0;
      r_r         <= '0;
      div_start_r <= 1'b0;
      div_a_r     <= '0;
      div_b_r     <= '0;
    end else begin
      div_start_r <= 1'b0;
      done_r      <= 2'b00;
      case (state_r)
        IDLE: begin
          if (|req) begin
            grant_r <= pick_s;
            div_a_r <= a_pick_s;
            div_b_r <= b_pick_s;
            // A zero divisor never reaches the divider
            if (b_pick_s == '0) begin
              done_r  <= onehot(pick_s);
              err_r   <= onehot(pick_s);
              q_r     <= {W{1'b1}};
              r_r     <= a_pick_s;
              state_r <= DONE;
            end else begin
              div_start_r <= 1'b1;
              state_r     <= START;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          cnt_r   <= '0;
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          cnt_r <= cnt_inc_s;
          if (expire_s) begin
            done_r  <= onehot(grant_r);
            err_r   <= onehot(grant_r);
            q_r     <= '0;
            r_r     <= '0;
            state_r <= DONE;
          end else if (state_r == WAIT_BUSY) begin
            state_r <= div_ready ? WAIT_BUSY : WAIT_DONE;
          end else if (div_ready) begin
            done_r  <= onehot(grant_r);
            err_r   <= 2'b00;
            q_r     <= div_qbus;
            r_r     <= div_rbus;
            state_r <= DONE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        DONE: begin
          ptr_r   <= ~grant_r;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done      = done_r;
  assign err       = err_r;
  assign qbus      = q_r;
  assign rbus      = r_r;
  assign div_start = div_start_r;
  assign div_abus  = div_a_r;
  assign div_bbus  = div_b_r;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: behavioural divider stub plus a round-robin/arithmetic
// reference, with directed corner cases followed by randomized operations.
module tb_divider_arbiter;
  localparam int W  = 9;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] abus0 = '0, bbus0 = '0, abus1 = '0, bbus1 = '0;
  logic [1:0]   done, err;
  logic [W-1:0] qbus, rbus, div_abus, div_bbus;
  logic         div_start;
  logic [W-1:0] div_qbus, div_rbus;
  logic         div_ready;

  // divider stub: mode 0 normal, 1 never completes, 2 ignores start (ready stuck high)
  int mode = 0;
  int lat  = 4;
  int lcnt;
  int starts = 0;

  int checks = 0;
  int fails  = 0;
  bit ptr    = 1'b0;

  divider_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .abus0(abus0), .bbus0(bbus0), .abus1(abus1), .bbus1(bbus1),
    .done(done), .err(err), .qbus(qbus), .rbus(rbus),
    .div_start(div_start), .div_abus(div_abus), .div_bbus(div_bbus),
    .div_qbus(div_qbus), .div_rbus(div_rbus), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_start) starts <= starts + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ready <= 1'b1;
      div_qbus  <= '0;
      div_rbus  <= '0;
      lcnt      <= 0;
    end else if (div_start && mode != 2) begin
      div_ready <= 1'b0;
      lcnt      <= lat;
      div_qbus  <= (div_bbus != 0) ? W'(div_abus / div_bbus) : '1;
      div_rbus  <= (div_bbus != 0) ? W'(div_abus % div_bbus) : div_abus;
    end else if (!div_ready && mode != 1) begin
      if (lcnt <= 1) div_ready <= 1'b1;
      else lcnt <= lcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit scr, input bit side, output int cyc);
    cyc = 0;
    while (done === 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (scr && cyc == 1) begin
        // operands after the grant must not matter
        if (side) begin abus1 = W'($urandom); bbus1 = W'($urandom); end
        else begin abus0 = W'($urandom); bbus0 = W'($urandom); end
      end
    end
    check("done_seen", {31'd0, done !== 2'b00}, 32'd1);
  endtask

  // kind: 0 normal divide, 1 divide-by-zero, 2 timeout
  task automatic serve(input bit side, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int kind, input bit scr);
    int cyc;
    int s0;
    logic [W-1:0] eq, er;
    logic [1:0] oh;
    s0 = starts;
    wait_done(scr, side, cyc);
    oh = side ? 2'b10 : 2'b01;
    if (kind == 0) begin eq = a / b; er = a % b; end
    else if (kind == 1) begin eq = '1; er = a; end
    else begin eq = '0; er = '0; end
    check("done", done, oh);
    check("err", err, (kind == 0) ? 2'b00 : oh);
    check("qbus", qbus, eq);
    check("rbus", rbus, er);
    if (kind == 1) check("dz_latency", cyc, 1);
    if (kind == 2) check("timeout_window", {31'd0, (cyc >= TO && cyc <= TO + 4)}, 32'd1);
    check("start_pulses", starts - s0, (kind == 1) ? 0 : 1);
    req[side] = 1'b0;
    ptr = ~side;
    @(negedge clk);
    check("done_pulse", done, 2'b00);
  endtask

  task automatic single(input bit side, input logic [W-1:0] a, input logic [W-1:0] b, input int kind);
    if (side) begin abus1 = a; bbus1 = b; end
    else begin abus0 = a; bbus0 = b; end
    req[side] = 1'b1;
    serve(side, a, b, kind, 1'b1);
  endtask

  task automatic both(input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1);
    bit first;
    abus0 = a0; bbus0 = b0; abus1 = a1; bbus1 = b1;
    req = 2'b11;
    first = ptr;
    if (first) serve(1'b1, a1, b1, (b1 == 0) ? 1 : 0, 1'b0);
    else serve(1'b0, a0, b0, (b0 == 0) ? 1 : 0, 1'b0);
    if (first) serve(1'b0, a0, b0, (b0 == 0) ? 1 : 0, 1'b0);
    else serve(1'b1, a1, b1, (b1 == 0) ? 1 : 0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a0, b0, a1, b1;
    int pat;
    repeat (3) @(negedge clk);
    check("rst_done", done, 2'b00);
    check("rst_err", err, 2'b00);
    check("rst_qbus", qbus, 0);
    check("rst_start", div_start, 0);
    check("rst_div_abus", div_abus, 0);
    rst = 1'b1;
    @(negedge clk);

    single(1'b0, 9'd65, 9'd2, 0);
    single(1'b1, 9'd129, 9'd3, 0);
    both(9'd100, 9'd7, 9'd200, 9'd9);
    both(9'd311, 9'd12, 9'd45, 9'd45);
    single(1'b0, 9'd17, 9'd0, 1);

    mode = 1;
    single(1'b1, 9'd50, 9'd5, 2);
    mode = 0;
    repeat (15) @(negedge clk);
    mode = 2;
    single(1'b0, 9'd77, 9'd6, 2);
    mode = 0;
    repeat (3) @(negedge clk);

    // reset while the divider is busy
    lat = 30;
    abus0 = 9'd90; bbus0 = 9'd4; req = 2'b01;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_done", done, 2'b00);
    check("midrst_start", div_start, 0);
    check("midrst_qbus", qbus, 0);
    check("midrst_div_abus", div_abus, 0);
    req = 2'b00;
    ptr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 2'b00);
    end
    rst = 1'b1;
    lat = 5;
    @(negedge clk);
    single(1'b1, 9'd500, 9'd7, 0);

    for (int i = 0; i < 20; i++) begin
      pat = $urandom_range(1, 3);
      lat = $urandom_range(2, 10);
      a0 = W'($urandom); a1 = W'($urandom);
      b0 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      b1 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if (pat == 3) both(a0, b0, a1, b1);
      else if (pat == 2) single(1'b1, a1, b1, (b1 == 0) ? 1 : 0);
      else single(1'b0, a0, b0, (b0 == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
